// File: rtl/mem_stage_dcache_if.sv
// Bundle between the MEM pipeline stage, the data cache and its backing memory.
// The cache uses the slave view; the driving side (pipeline + memory model) uses master.
interface mem_stage_dcache_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       ResultSrcM;
    logic             MemWriteM;
    logic [2:0]       TypeM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] ReadDataM;
    logic             StallM;
    logic             MemReqO;
    logic             MemWeO;
    logic [WIDTH-1:0] MemAddrO;
    logic [WIDTH-1:0] MemWDataO;
    logic [3:0]       MemBeO;
    logic             MemAckI;
    logic [WIDTH-1:0] MemRDataI;

    modport slave (
        input  ResultSrcM, MemWriteM, TypeM, ALUResultM, WriteDataM, MemAckI, MemRDataI,
        output ReadDataM, StallM, MemReqO, MemWeO, MemAddrO, MemWDataO, MemBeO
    );

    modport master (
        output ResultSrcM, MemWriteM, TypeM, ALUResultM, WriteDataM, MemAckI, MemRDataI,
        input  ReadDataM, StallM, MemReqO, MemWeO, MemAddrO, MemWDataO, MemBeO
    );
endinterface

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache for the MEM stage.
// Load hits return extended data combinationally; misses and all stores go to backing memory.
module mem_stage_dcache #(
    parameter int WIDTH = 32,
    parameter int LINES = 64
) (
    input logic CLK,
    input logic RST,
    mem_stage_dcache_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WIDTH - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       data_q [LINES];
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [LINES-1:0]       valid_q;
    logic [WIDTH-1:2]       mem_addr_q;
    logic                   mem_we_q;
    logic [WIDTH-1:0]       mem_wdata_q;
    logic [3:0]             mem_be_q;

    logic                   load;
    logic                   hit;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             lo;
    logic [IDX_W-1:0]       widx;
    logic [TAG_W-1:0]       wtag;
    logic [WIDTH-1:0]       st_wdata;
    logic [3:0]             st_be;
    logic [WIDTH-1:0]       line;

    function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] w,
                                                     input logic [2:0] ty,
                                                     input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (ty[1:0])
            2'b00:   load_extend = {{(WIDTH-8){b[7] & ~ty[2]}}, b};
            2'b01:   load_extend = {{(WIDTH-16){h[15] & ~ty[2]}}, h};
            default: load_extend = w;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [3:0] be);
        merge = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge[i*8 +: 8] = new_w[i*8 +: 8];
    endfunction

    assign load = (bus.ResultSrcM == 2'b01);
    assign idx  = bus.ALUResultM[IDX_W+1:2];
    assign tag  = bus.ALUResultM[WIDTH-1:IDX_W+2];
    assign lo   = bus.ALUResultM[1:0];
    assign line = data_q[idx];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign widx = mem_addr_q[IDX_W+1:2];
    assign wtag = mem_addr_q[WIDTH-1:IDX_W+2];

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        st_wdata = bus.WriteDataM;
        st_be    = 4'b1111;
        case (bus.TypeM[1:0])
            2'b00: begin
                st_wdata = {4{bus.WriteDataM[7:0]}};
                st_be    = 4'b0001 << lo;
            end
            2'b01: begin
                st_wdata = {2{bus.WriteDataM[15:0]}};
                st_be    = lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.StallM = 1'b0;
        case (state)
            IDLE:             bus.StallM = bus.MemWriteM | (load & ~hit);
            RD_WAIT, WR_WAIT: bus.StallM = 1'b1;
            default:          bus.StallM = 1'b0;
        endcase
        if (RST) bus.StallM = 1'b0;
    end

    // In DONE the inputs are still held, so idx points at the line just filled.
    always_comb begin
        bus.ReadDataM = '0;
        if (load && !RST && ((state == IDLE && hit) || state == DONE))
            bus.ReadDataM = load_extend(line, bus.TypeM, lo);
    end

    assign bus.MemReqO   = (state == RD_WAIT) || (state == WR_WAIT);
    assign bus.MemWeO    = mem_we_q;
    assign bus.MemAddrO  = {mem_addr_q, 2'b00};
    assign bus.MemWDataO = mem_wdata_q;
    assign bus.MemBeO    = mem_be_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            valid_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MemWriteM) begin
                        mem_addr_q  <= bus.ALUResultM[WIDTH-1:2];
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= st_wdata;
                        mem_be_q    <= st_be;
                        state       <= WR_WAIT;
                    end else if (load && !hit) begin
                        mem_addr_q  <= bus.ALUResultM[WIDTH-1:2];
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'b1111;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.MemAckI) begin
                        data_q[widx]  <= bus.MemRDataI;
                        tag_q[widx]   <= wtag;
                        valid_q[widx] <= 1'b1;
                        state         <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (bus.MemAckI) begin
                        // No write-allocate: only an already-resident line is updated.
                        if (valid_q[widx] && tag_q[widx] == wtag)
                            data_q[widx] <= merge(data_q[widx], mem_wdata_q, mem_be_q);
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: load hit/miss, extension, store merge, no-allocate, reset abort.
module tb_mem_stage_dcache;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] cap_wdata;

    mem_stage_dcache_if #(.WIDTH(32)) bus ();
    mem_stage_dcache #(.WIDTH(32), .LINES(64)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] rs, input logic mw, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd);
        bus.ResultSrcM = rs;
        bus.MemWriteM  = mw;
        bus.TypeM      = ty;
        bus.ALUResultM = a;
        bus.WriteDataM = wd;
    endtask

    task automatic idle_op();
        set_op(2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for a request, checks its fields, acks after 'delay' cycles; returns in DONE.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] rdata, input int delay);
        int n = 0;
        while (!bus.MemReqO && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'b0, bus.MemReqO}, 32'h1);
        if (!bus.MemReqO) return;
        chk({tag, "_addr"}, bus.MemAddrO, exp_addr);
        chk({tag, "_we"}, {31'b0, bus.MemWeO}, {31'b0, exp_we});
        chk({tag, "_be"}, {28'b0, bus.MemBeO}, {28'b0, exp_be});
        cap_wdata = bus.MemWDataO;
        repeat (delay - 1) tick();
        chk({tag, "_addr_held"}, bus.MemAddrO, exp_addr);
        chk({tag, "_stall_wait"}, {31'b0, bus.StallM}, 32'h1);
        bus.MemAckI   = 1'b1;
        bus.MemRDataI = rdata;
        tick();
        bus.MemAckI   = 1'b0;
        bus.MemRDataI = 32'hDEAD_BEEF;
        chk({tag, "_done_req"}, {31'b0, bus.MemReqO}, 32'h0);
        chk({tag, "_done_stall"}, {31'b0, bus.StallM}, 32'h0);
    endtask

    // Single-cycle hit: no stall, no request, extended data.
    task automatic hit_load(input string tag, input logic [2:0] ty, input logic [31:0] a,
                            input logic [31:0] exp);
        set_op(2'b01, 1'b0, ty, a, 32'h0);
        #1;
        chk({tag, "_data"}, bus.ReadDataM, exp);
        chk({tag, "_stall"}, {31'b0, bus.StallM}, 32'h0);
        tick();
        chk({tag, "_noreq"}, {31'b0, bus.MemReqO}, 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        bus.MemAckI   = 1'b0;
        bus.MemRDataI = 32'h0;
        idle_op();
        repeat (2) tick();
        RST = 1'b0;
        #1;
        chk("rst_req", {31'b0, bus.MemReqO}, 32'h0);
        chk("rst_stall", {31'b0, bus.StallM}, 32'h0);
        chk("rst_rdata", bus.ReadDataM, 32'h0);
        tick();

        // T1: cold miss, fill, then hit
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        chk("t1_stall_detect", {31'b0, bus.StallM}, 32'h1);
        chk("t1_noreq_detect", {31'b0, bus.MemReqO}, 32'h0);
        serve("t1", 32'h100, 1'b0, 4'b1111, 32'h8765_80F0, 3);
        chk("t1_done_data", bus.ReadDataM, 32'h8765_80F0);
        tick();
        hit_load("t1_hit", 3'b010, 32'h100, 32'h8765_80F0);

        // T2: lane select and extension
        hit_load("t2_lb", 3'b000, 32'h101, 32'hFFFF_FF80);
        hit_load("t2_lbu", 3'b100, 32'h101, 32'h0000_0080);
        hit_load("t2_lh", 3'b001, 32'h102, 32'hFFFF_8765);
        hit_load("t2_lhu", 3'b101, 32'h102, 32'h0000_8765);
        hit_load("t2_lb3", 3'b000, 32'h103, 32'hFFFF_FF87);
        hit_load("t2_lw_mis", 3'b010, 32'h103, 32'h8765_80F0);

        // T3: byte store hit merges into the line
        set_op(2'b00, 1'b1, 3'b000, 32'h103, 32'h0000_00AA);
        #1;
        chk("t3_stall_detect", {31'b0, bus.StallM}, 32'h1);
        serve("t3", 32'h100, 1'b1, 4'b1000, 32'h0, 2);
        chk("t3_wdata_b3", {24'b0, cap_wdata[31:24]}, 32'hAA);
        chk("t3_done_rdata", bus.ReadDataM, 32'h0);
        tick();
        idle_op();
        // stray ack with no request must be ignored
        bus.MemAckI   = 1'b1;
        bus.MemRDataI = 32'h1234_5678;
        tick();
        bus.MemAckI = 1'b0;
        chk("stray_ack_noreq", {31'b0, bus.MemReqO}, 32'h0);
        hit_load("t3_lw", 3'b010, 32'h100, 32'hAA65_80F0);
        hit_load("t3_lhu", 3'b101, 32'h100, 32'h0000_80F0);

        // Halfword store to the upper half
        set_op(2'b00, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
        serve("sh", 32'h100, 1'b1, 4'b1100, 32'h0, 1);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        tick();
        hit_load("sh_lw", 3'b010, 32'h100, 32'hBEEF_80F0);

        // T4: store miss writes through without allocating
        set_op(2'b00, 1'b1, 3'b010, 32'h200, 32'h1122_3344);
        serve("t4_sw", 32'h200, 1'b1, 4'b1111, 32'h0, 2);
        chk("t4_wdata", cap_wdata, 32'h1122_3344);
        tick();
        chk("t4_idle_noreq", {31'b0, bus.MemReqO}, 32'h0);
        set_op(2'b01, 1'b0, 3'b010, 32'h200, 32'h0);
        #1;
        chk("t4_lw_miss", {31'b0, bus.StallM}, 32'h1);
        serve("t4_lw", 32'h200, 1'b0, 4'b1111, 32'h1122_3344, 2);
        chk("t4_done_data", bus.ReadDataM, 32'h1122_3344);
        tick();

        // T5: conflicting index evicts the 0x100 line
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        chk("t5_lw_miss", {31'b0, bus.StallM}, 32'h1);
        serve("t5_lw", 32'h100, 1'b0, 4'b1111, 32'hBEEF_80F0, 2);
        chk("t5_done_data", bus.ReadDataM, 32'hBEEF_80F0);
        tick();
        hit_load("t5_hit", 3'b010, 32'h100, 32'hBEEF_80F0);

        // T6: reset during RD_WAIT abandons the access and clears valid bits
        set_op(2'b01, 1'b0, 3'b010, 32'h200, 32'h0);
        #1;
        chk("t6_miss", {31'b0, bus.StallM}, 32'h1);
        tick();
        chk("t6_req", {31'b0, bus.MemReqO}, 32'h1);
        RST = 1'b1;
        tick();
        chk("t6_rst_noreq", {31'b0, bus.MemReqO}, 32'h0);
        chk("t6_rst_nostall", {31'b0, bus.StallM}, 32'h0);
        RST = 1'b0;
        set_op(2'b01, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        chk("t6_lw_after_rst_miss", {31'b0, bus.StallM}, 32'h1);
        serve("t6_lw", 32'h100, 1'b0, 4'b1111, 32'h0BAD_F00D, 2);
        chk("t6_done_data", bus.ReadDataM, 32'h0BAD_F00D);
        tick();
        idle_op();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
